fft_stage_sched: RTL and testbench

- Sequences an in-place radix-2 DIT FFT across two ping-pong memory banks.
- Issues one butterfly per cycle: read address pair, twiddle index and source bank.
- Delays the same address pair by the datapath latency and drives the FFT write port of the memory mux (fft_waddra/b, fft_wea/b, wmem_id).
- Sits between the top-level FFT control (start/done) and the mem_mux; butterfly data itself bypasses this block.

---
 rtl/fft_stage_sched.sv | 153 +++++++++++++++
 tb/tb_fft_stage_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sched.sv
// fft_stage_sched: address/bank sequencer for an in-place radix-2 DIT FFT
// over two ping-pong banks, with a delayed write-address port.
module fft_stage_sched #(
    parameter int FFT_SIZE   = 4096,
    parameter int ADDR_WIDTH = 12,
    parameter int PIPE_LAT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_mem_id,
    output logic                          busy,
    output logic                          done,
    output logic                          out_mem_id,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         fft_raddra,
    output logic [ADDR_WIDTH-1:0]         fft_raddrb,
    output logic                          rmem_id,
    output logic [ADDR_WIDTH-2:0]         tw_idx,
    output logic [$clog2(ADDR_WIDTH):0]   stage,
    output logic [ADDR_WIDTH-1:0]         fft_waddra,
    output logic [ADDR_WIDTH-1:0]         fft_waddrb,
    output logic                          fft_wea,
    output logic                          fft_web,
    output logic                          wmem_id
);

    localparam int SW = $clog2(ADDR_WIDTH) + 1;
    localparam int KW = ADDR_WIDTH - 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(FFT_SIZE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(ADDR_WIDTH - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [SW-1:0]   s;
    logic [DW-1:0]   d;

    logic [ADDR_WIDTH-1:0] kw;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] pos;
    logic [ADDR_WIDTH-1:0] grp;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [KW-1:0]         tw_full;

    // Butterfly k of stage s: insert a zero at bit s of k to get the top address.
    always_comb begin
        kw      = {1'b0, k};
        span    = ONE << s;
        pos     = kw & (span - ONE);
        grp     = kw >> s;
        a_addr  = ((grp << s) << 1) | pos;
        b_addr  = a_addr | span;
        tw_full = KW'(pos) << (S_LAST - s);
    end

    assign fft_raddra = rd_en ? a_addr : '0;
    assign fft_raddrb = rd_en ? b_addr : '0;
    assign tw_idx     = rd_en ? tw_full : '0;
    assign stage      = s;
    assign wmem_id    = busy & ~rmem_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            s          <= '0;
            d          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rmem_id    <= 1'b0;
            out_mem_id <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state   <= RUN;
                        rmem_id <= in_mem_id;
                        s       <= '0;
                        k       <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state <= DRAIN;
                        k     <= '0;
                        d     <= '0;
                        rd_en <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (d != D_LAST) begin
                        d <= d + 1'b1;
                    end else if (s == S_LAST) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        out_mem_id <= ~rmem_id;
                    end else begin
                        state   <= RUN;
                        s       <= s + 1'b1;
                        rmem_id <= ~rmem_id;
                        rd_en   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic                  dl_en [PIPE_LAT];
    logic [ADDR_WIDTH-1:0] dl_a  [PIPE_LAT];
    logic [ADDR_WIDTH-1:0] dl_b  [PIPE_LAT];

    // Read pair travels alongside the datapath so writes land in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_en[i] <= 1'b0;
                dl_a[i]  <= '0;
                dl_b[i]  <= '0;
            end
        end else begin
            dl_en[0] <= rd_en;
            dl_a[0]  <= fft_raddra;
            dl_b[0]  <= fft_raddrb;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a[i]  <= dl_a[i-1];
                dl_b[i]  <= dl_b[i-1];
            end
        end
    end

    assign fft_wea    = dl_en[PIPE_LAT-1];
    assign fft_web    = dl_en[PIPE_LAT-1];
    assign fft_waddra = dl_a[PIPE_LAT-1];
    assign fft_waddrb = dl_b[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_stage_sched.sv
// tb_fft_stage_sched: directed checks of the FFT schedule on an 8-point
// instance (PIPE_LAT=2) and a default 4096-point instance.
module tb_fft_stage_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       start, in_mem_id;
    logic       busy, done, out_mem_id, rd_en, rmem_id;
    logic [2:0] fft_raddra, fft_raddrb, fft_waddra, fft_waddrb;
    logic [1:0] tw_idx;
    logic [2:0] stage;
    logic       fft_wea, fft_web, wmem_id;

    fft_stage_sched #(.FFT_SIZE(8), .ADDR_WIDTH(3), .PIPE_LAT(2)) u_small (
        .clk(clk), .rst(rst), .start(start), .in_mem_id(in_mem_id),
        .busy(busy), .done(done), .out_mem_id(out_mem_id), .rd_en(rd_en),
        .fft_raddra(fft_raddra), .fft_raddrb(fft_raddrb), .rmem_id(rmem_id),
        .tw_idx(tw_idx), .stage(stage), .fft_waddra(fft_waddra),
        .fft_waddrb(fft_waddrb), .fft_wea(fft_wea), .fft_web(fft_web),
        .wmem_id(wmem_id)
    );

    logic        b_start, b_in;
    logic        b_busy, b_done, b_out, b_rd, b_rmem;
    logic [11:0] b_ra, b_rb, b_wa, b_wb;
    logic [10:0] b_tw;
    logic [4:0]  b_stage;
    logic        b_wea, b_web, b_wmem;

    fft_stage_sched u_big (
        .clk(clk), .rst(rst), .start(b_start), .in_mem_id(b_in),
        .busy(b_busy), .done(b_done), .out_mem_id(b_out), .rd_en(b_rd),
        .fft_raddra(b_ra), .fft_raddrb(b_rb), .rmem_id(b_rmem),
        .tw_idx(b_tw), .stage(b_stage), .fft_waddra(b_wa),
        .fft_waddrb(b_wb), .fft_wea(b_wea), .fft_web(b_web),
        .wmem_id(b_wmem)
    );

    typedef struct {
        int ra; int rb; int tw; int rm; int st; int cy;
    } rd_t;
    typedef struct {
        int wa; int wb; int ea; int eb; int wm; int cy;
    } wr_t;

    rd_t rq[$];
    wr_t wq[$];
    int  dn_cnt = 0;
    int  dn_cyc = 0;
    int  dn_busy = 0;

    int exp_ra[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_rb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        if (rd_en) begin
            r.ra = int'(fft_raddra); r.rb = int'(fft_raddrb);
            r.tw = int'(tw_idx);     r.rm = int'(rmem_id);
            r.st = int'(stage);      r.cy = cyc;
            rq.push_back(r);
        end
        if (fft_wea || fft_web) begin
            w.wa = int'(fft_waddra); w.wb = int'(fft_waddrb);
            w.ea = int'(fft_wea);    w.eb = int'(fft_web);
            w.wm = int'(wmem_id);    w.cy = cyc;
            wq.push_back(w);
        end
        if (done) begin
            dn_cnt++;
            dn_cyc  = cyc;
            dn_busy = int'(busy);
        end
    end

    int b_reads = 0, b_writes = 0, b_haz = 0, b_dn_cnt = 0, b_dn_cyc = 0;
    int pend[2][4096];

    always @(negedge clk) begin
        if (b_rd) begin
            b_reads++;
            if (pend[b_rmem][b_ra] != 0 || pend[b_rmem][b_rb] != 0) b_haz++;
            pend[!b_rmem][b_ra]++;
            pend[!b_rmem][b_rb]++;
        end
        if (b_wea) begin
            b_writes++;
            pend[b_wmem][b_wa]--;
            pend[b_wmem][b_wb]--;
        end
        if (b_done) begin
            b_dn_cnt++;
            b_dn_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_xfm(input logic mem, input bit poke);
        int t0;
        rq.delete();
        wq.delete();
        dn_cnt = 0;
        tick();
        start = 1'b1;
        in_mem_id = mem;
        t0 = cyc;
        for (int n = 0; n < 60 && dn_cnt == 0; n++) begin
            tick();
            start = poke && (cyc == t0 + 8);
            in_mem_id = start ? ~mem : mem;
        end
        start = 1'b0;
        in_mem_id = mem;
        chk("done_seen", dn_cnt, 1);
        chk("done_cyc", dn_cyc, t0 + 19);
        chk("busy_at_done", dn_busy, 0);
        chk("out_mem_id", out_mem_id, mem ^ 1'b1);
        chk("n_reads", rq.size(), 12);
        chk("n_writes", wq.size(), 12);
        for (int i = 0; i < 12 && i < rq.size(); i++) begin
            chk($sformatf("ra%0d", i), rq[i].ra, exp_ra[i]);
            chk($sformatf("rb%0d", i), rq[i].rb, exp_rb[i]);
            chk($sformatf("tw%0d", i), rq[i].tw, exp_tw[i]);
            chk($sformatf("st%0d", i), rq[i].st, i / 4);
            chk($sformatf("rm%0d", i), rq[i].rm, mem ^ ((i / 4) % 2));
            chk($sformatf("rcy%0d", i), rq[i].cy,
                t0 + 1 + (i / 4) * 6 + (i % 4));
        end
        for (int i = 0; i < wq.size() && i < rq.size(); i++) begin
            chk($sformatf("wa%0d", i), wq[i].wa, rq[i].ra);
            chk($sformatf("wb%0d", i), wq[i].wb, rq[i].rb);
            chk($sformatf("wea%0d", i), wq[i].ea, 1);
            chk($sformatf("web%0d", i), wq[i].eb, 1);
            chk($sformatf("wm%0d", i), wq[i].wm, rq[i].rm ^ 1);
            chk($sformatf("wcy%0d", i), wq[i].cy, rq[i].cy + 2);
        end
    endtask

    initial begin
        int t0;
        int nw;
        rst = 1'b1;
        start = 1'b0;
        in_mem_id = 1'b0;
        b_start = 1'b0;
        b_in = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_raddrb", fft_raddrb, 0);
        chk("rst_stage", stage, 0);
        chk("rst_wea", fft_wea, 0);
        chk("rst_wmem", wmem_id, 0);
        chk("rst_out_mem", out_mem_id, 0);
        rst = 1'b0;
        tick();

        // first run pokes start mid stage 1; second starts right after done
        run_xfm(1'b0, 1'b1);
        run_xfm(1'b1, 1'b0);

        tick();
        start = 1'b1;
        in_mem_id = 1'b0;
        t0 = cyc;
        tick();
        start = 1'b0;
        while (cyc < t0 + 11) tick();
        chk("drain_busy", busy, 1);
        chk("drain_stage", stage, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_stage", stage, 0);
        chk("abort_rmem", rmem_id, 0);
        chk("abort_wea", fft_wea, 0);
        chk("abort_waddra", fft_waddra, 0);
        chk("abort_waddrb", fft_waddrb, 0);
        chk("abort_out_mem", out_mem_id, 0);
        nw = wq.size();
        dn_cnt = 0;
        repeat (30) tick();
        chk("abort_no_write", wq.size(), nw);
        chk("abort_no_done", dn_cnt, 0);
        run_xfm(1'b0, 1'b0);

        tick();
        b_start = 1'b1;
        b_in = 1'b1;
        t0 = cyc;
        tick();
        b_start = 1'b0;
        for (int n = 0; n < 25000 && b_dn_cnt == 0; n++) tick();
        chk("big_done_seen", b_dn_cnt, 1);
        chk("big_done_cyc", b_dn_cyc, t0 + 24625);
        chk("big_reads", b_reads, 12 * 2048);
        chk("big_writes", b_writes, 12 * 2048);
        chk("big_out_mem", b_out, 1);
        chk("big_hazards", b_haz, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
